count_gate_step: RTL and testbench
==================================

# count_gate_step

Parametrised up/down counter, next generation of the clock-chain counter stage. It adds:
- a runtime window (min_count..max_count) and programmable step size;
- a wrap or saturate mode, synchronous load and clear;
- sticky overflow/underflow flags.

Its combinational done outputs drive the en input of the next stage (seconds -> minutes -> hours ...) in the same cycle.

## Interface
- NUM_BIT, 7, counter width; legal range 2..32.
- RESET_VALUE, 0, value taken on reset_n low and on clr; must be < 2^NUM_BIT.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; gates inc/dec only.
- inc  input  1  count up by step.
- dec  input  1  count down by step.
- step  input  NUM_BIT  increment/decrement amount; 0 means hold.
- min_count  input  NUM_BIT  lower window bound.
- max_count  input  NUM_BIT  upper window bound.
- mode_sat  input  1  0 = wrap, 1 = saturate.
- load  input  1  synchronous load of load_val.
- load_val  input  NUM_BIT  value to load; clamped to the window.
- clr  input  1  synchronous clear to RESET_VALUE.
- flag_ack  input  1  clears the sticky flags.
- count_o  output  NUM_BIT  registered count.
- done_inc  output  1  combinational: the accepted increment crosses max_count.
- done_dec  output  1  combinational: the accepted decrement crosses min_count.
- ovf_sticky  output  1  registered; set by done_inc.
- unf_sticky  output  1  registered; set by done_dec.
- cfg_err  output  1  combinational: min_count > max_count.

## Operation
- Priority, highest first: clr > load > count (en & inc ^ dec) > hold.
- clr loads RESET_VALUE. load stores load_val clamped to [min_count, max_count]. Neither is gated by en.
- inc and dec both high, or en low: hold, no done pulse.
- All arithmetic uses NUM_BIT+1 bits; no silent truncation.
  - up_sum = count_o + step
  - dn_ok = (count_o >= min_count + step), with the sum computed at NUM_BIT+1 bits.
- Increment:
  - up_sum <= max_count: count <- up_sum.
  - Otherwise overflow. Wrap mode: count <- min_count. Saturate mode: count <- max_count. done_inc = 1.
- Decrement:
  - dn_ok: count <- count_o - step.
  - Otherwise underflow. Wrap mode: count <- max_count. Saturate mode: count <- min_count. done_dec = 1.
- Special cases:
  - step = 0: hold, no done pulse.
  - With step = 1, overflow is exactly count_o == max_count, as in the legacy stage.
  - Saturate mode at a bound still pulses done every accepted step.
- Out-of-range recovery: count_o outside the window on an accepted inc/dec gives count <- min_count, no done pulse. This happens after a window change.
- cfg_err = 1: inc/dec are ignored (hold, no done). clr and load still act; load clamps to min_count.
- done_inc = en & inc & ~dec & ~load & ~clr & ~cfg_err & in_window & overflow. done_dec is symmetric.
- Sticky flags:
  - Set in the cycle after done_inc/done_dec.
  - Cleared by flag_ack or clr. A set in the same cycle as flag_ack wins.

## Timing
- Reset values: count_o = RESET_VALUE; ovf_sticky = 0; unf_sticky = 0.
- During reset: done_inc = done_dec = 0. cfg_err follows its inputs.
- count_o updates on the clk edge after the request; latency is 1 cycle.
- done_* are valid in the same cycle as the request, before the edge. They carry no internal register, so a cascade of k stages rolls over in one clock.
- Sticky flags are visible 1 cycle after the done pulse.
- A reset_n assertion mid-count forces the reset values immediately, with no clock needed. Deassertion is synchronised externally.
- Window inputs are sampled combinationally each cycle. A change takes effect on the next accepted operation.

## Test plan
- Reset and wrap (NUM_BIT=7, min 0, max 59, step 1, wrap):
  - Assert reset_n=0 mid-count -> count_o=0 at once.
  - Apply 60 inc -> done_inc high on the 60th cycle, count_o back to 0, ovf_sticky=1 one cycle later.
- Saturate with step: min 10, max 20, step 4, start 18, inc -> count_o=20, done_inc=1.
- Saturated decrement: from 11, dec -> count_o=10, done_dec=1.
- Wrap decrement: wrap mode, min 1, max 12, count 1, dec -> count_o=12, done_dec=1.
- Both inc and dec high -> hold, no done.
- Load clamp and priority: max 23, load_val 99 -> count_o=23.
- load together with inc at max -> load wins, done_inc=0.
- clr together with load -> count_o=RESET_VALUE, sticky flags cleared.
- Window change: count 50, max lowered to 30, inc -> count_o=min_count, no done.
- Misconfiguration: min 40 > max 30 -> cfg_err=1, inc/dec hold.
- Cascade: two instances, sec.done_inc drives min.en, min=0..59 -> at 59:59 a single inc gives 00:00 in one clock, with both done pulses in the same cycle.

Source files
------------

// File: rtl/count_gate_step.sv
// Windowed up/down counter stage with programmable step, wrap/saturate mode,
// sticky over/underflow flags and combinational done outputs for cascading.
module count_gate_step #(
  parameter int          NUM_BIT     = 7,
  parameter int unsigned RESET_VALUE = 32'd0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               inc,
  input  logic               dec,
  input  logic [NUM_BIT-1:0] step,
  input  logic [NUM_BIT-1:0] min_count,
  input  logic [NUM_BIT-1:0] max_count,
  input  logic               mode_sat,
  input  logic               load,
  input  logic [NUM_BIT-1:0] load_val,
  input  logic               clr,
  input  logic               flag_ack,
  output logic [NUM_BIT-1:0] count_o,
  output logic               done_inc,
  output logic               done_dec,
  output logic               ovf_sticky,
  output logic               unf_sticky,
  output logic               cfg_err
);

  localparam logic [NUM_BIT-1:0] RST_VAL = RESET_VALUE[NUM_BIT-1:0];

  logic [NUM_BIT-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;

  logic [NUM_BIT:0]   up_sum_s;
  logic [NUM_BIT:0]   min_plus_s;
  logic               dn_ok_s;
  logic               overflow_s;
  logic               in_window_s;
  logic               step_nz_s;
  logic               acc_inc_s;
  logic               acc_dec_s;
  logic [NUM_BIT-1:0] load_clamp_s;

  // Arithmetic is one bit wider than the counter so sums never truncate.
  always_comb begin
    up_sum_s    = {1'b0, count_q} + {1'b0, step};
    min_plus_s  = {1'b0, min_count} + {1'b0, step};
    dn_ok_s     = ({1'b0, count_q} >= min_plus_s);
    overflow_s  = (up_sum_s > {1'b0, max_count});
    in_window_s = (count_q >= min_count) && (count_q <= max_count);
    step_nz_s   = (step != {NUM_BIT{1'b0}});
    cfg_err     = (min_count > max_count);
  end

  // Accepted requests; reset_n gating keeps done low while in reset.
  always_comb begin
    acc_inc_s = reset_n & en & inc & ~dec & ~load & ~clr & ~cfg_err & step_nz_s;
    acc_dec_s = reset_n & en & dec & ~inc & ~load & ~clr & ~cfg_err & step_nz_s;
    done_inc  = acc_inc_s & in_window_s & overflow_s;
    done_dec  = acc_dec_s & in_window_s & ~dn_ok_s;
  end

  // Load value clamped to the window; a broken window forces min_count.
  always_comb begin
    if (cfg_err) begin
      load_clamp_s = min_count;
    end else if (load_val < min_count) begin
      load_clamp_s = min_count;
    end else if (load_val > max_count) begin
      load_clamp_s = max_count;
    end else begin
      load_clamp_s = load_val;
    end
  end

  // Next count: clr > load > inc/dec > hold; out-of-window recovers to min.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = RST_VAL;
    end else if (load) begin
      count_d = load_clamp_s;
    end else if (acc_inc_s) begin
      if (!in_window_s) begin
        count_d = min_count;
      end else if (overflow_s) begin
        count_d = mode_sat ? max_count : min_count;
      end else begin
        count_d = up_sum_s[NUM_BIT-1:0];
      end
    end else if (acc_dec_s) begin
      if (!in_window_s) begin
        count_d = min_count;
      end else if (!dn_ok_s) begin
        count_d = mode_sat ? min_count : max_count;
      end else begin
        count_d = count_q - step;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Sticky flags: a new done pulse beats a same-cycle acknowledge.
  always_comb begin
    ovf_d = done_inc | (ovf_q & ~(flag_ack | clr));
    unf_d = done_dec | (unf_q & ~(flag_ack | clr));
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RST_VAL;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count_o    = count_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;

endmodule

// File: tb/tb_count_gate_step.sv
// Directed bench for count_gate_step: a seconds stage plus a minutes stage
// chained through done_inc.
module tb_count_gate_step;

  logic       clk;
  logic       reset_n;
  logic       en, inc, dec, mode_sat, load, clr, flag_ack;
  logic [6:0] step, min_count, max_count, load_val;
  logic [6:0] count_o;
  logic       done_inc, done_dec, ovf_sticky, unf_sticky, cfg_err;

  logic       m_inc, m_load;
  logic [6:0] m_step, m_min, m_max, m_load_val;
  logic       m_mode, m_clr, m_ack, m_dec;
  logic [6:0] m_count;
  logic       m_done_inc, m_done_dec, m_ovf, m_unf, m_cfg_err;

  int total = 0;
  int bad   = 0;

  count_gate_step #(.NUM_BIT(7), .RESET_VALUE(32'd0)) u_sec (
    .clk(clk), .reset_n(reset_n), .en(en), .inc(inc), .dec(dec), .step(step),
    .min_count(min_count), .max_count(max_count), .mode_sat(mode_sat),
    .load(load), .load_val(load_val), .clr(clr), .flag_ack(flag_ack),
    .count_o(count_o), .done_inc(done_inc), .done_dec(done_dec),
    .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky), .cfg_err(cfg_err)
  );

  count_gate_step #(.NUM_BIT(7), .RESET_VALUE(32'd0)) u_min (
    .clk(clk), .reset_n(reset_n), .en(done_inc), .inc(m_inc), .dec(m_dec),
    .step(m_step), .min_count(m_min), .max_count(m_max), .mode_sat(m_mode),
    .load(m_load), .load_val(m_load_val), .clr(m_clr), .flag_ack(m_ack),
    .count_o(m_count), .done_inc(m_done_inc), .done_dec(m_done_dec),
    .ovf_sticky(m_ovf), .unf_sticky(m_unf), .cfg_err(m_cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; inc = 1'b0; dec = 1'b0; mode_sat = 1'b0;
    load = 1'b0; clr = 1'b0; flag_ack = 1'b0;
    step = 7'd1; min_count = 7'd0; max_count = 7'd59; load_val = 7'd0;
    m_inc = 1'b0; m_dec = 1'b0; m_load = 1'b0; m_load_val = 7'd0;
    m_step = 7'd1; m_min = 7'd0; m_max = 7'd59; m_mode = 1'b0;
    m_clr = 1'b0; m_ack = 1'b0;
    #2;
    check("rst_count", 32'(count_o), 0);
    check("rst_ovf", 32'(ovf_sticky), 0);
    check("rst_unf", 32'(unf_sticky), 0);
    inc = 1'b1;
    #1;
    check("rst_done_inc", 32'(done_inc), 0);
    inc = 1'b0;
    min_count = 7'd40; max_count = 7'd30;
    #1;
    check("rst_cfg_err", 32'(cfg_err), 1);
    min_count = 7'd0; max_count = 7'd59;
    tick();
    reset_n = 1'b1;
    tick();

    // Mid-count asynchronous reset
    inc = 1'b1;
    repeat (5) tick();
    check("pre_rst_count", 32'(count_o), 5);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count_o), 0);
    check("async_rst_done", 32'(done_inc), 0);
    inc = 1'b0;
    reset_n = 1'b1;
    tick();

    // 60 increments in wrap mode
    for (int i = 0; i < 60; i++) begin
      inc = 1'b1;
      #1;
      check("wrap_done_inc", 32'(done_inc), (i == 59) ? 1 : 0);
      tick();
    end
    inc = 1'b0;
    check("wrap_count", 32'(count_o), 0);
    check("wrap_ovf", 32'(ovf_sticky), 1);
    check("wrap_unf", 32'(unf_sticky), 0);
    flag_ack = 1'b1;
    tick();
    flag_ack = 1'b0;
    check("ack_ovf", 32'(ovf_sticky), 0);

    // Saturating increment with step 4
    mode_sat = 1'b1; min_count = 7'd10; max_count = 7'd20; step = 7'd4;
    load = 1'b1; load_val = 7'd18;
    tick();
    load = 1'b0;
    check("sat_load", 32'(count_o), 18);
    inc = 1'b1;
    #1;
    check("sat_done_inc", 32'(done_inc), 1);
    tick();
    inc = 1'b0;
    check("sat_inc_count", 32'(count_o), 20);
    check("sat_ovf", 32'(ovf_sticky), 1);

    // Saturating decrement
    load = 1'b1; load_val = 7'd11;
    tick();
    load = 1'b0;
    dec = 1'b1;
    #1;
    check("sat_done_dec", 32'(done_dec), 1);
    tick();
    check("sat_dec_count", 32'(count_o), 10);
    check("sat_unf", 32'(unf_sticky), 1);
    flag_ack = 1'b1;
    #1;
    check("sat_bound_done_dec", 32'(done_dec), 1);
    tick();
    dec = 1'b0; flag_ack = 1'b0;
    check("bound_count", 32'(count_o), 10);
    check("set_beats_ack", 32'(unf_sticky), 1);
    check("ack_clears_ovf", 32'(ovf_sticky), 0);

    // Wrap decrement
    mode_sat = 1'b0; min_count = 7'd1; max_count = 7'd12; step = 7'd1;
    load = 1'b1; load_val = 7'd1;
    tick();
    load = 1'b0;
    dec = 1'b1;
    #1;
    check("wrapdec_done", 32'(done_dec), 1);
    tick();
    dec = 1'b0;
    check("wrapdec_count", 32'(count_o), 12);

    // Both inc and dec
    inc = 1'b1; dec = 1'b1;
    #1;
    check("both_done_inc", 32'(done_inc), 0);
    check("both_done_dec", 32'(done_dec), 0);
    tick();
    inc = 1'b0; dec = 1'b0;
    check("both_count", 32'(count_o), 12);

    // Load clamp, then load beats inc at max
    min_count = 7'd0; max_count = 7'd23;
    load = 1'b1; load_val = 7'd99;
    tick();
    load = 1'b0;
    check("load_clamp", 32'(count_o), 23);
    inc = 1'b1; load = 1'b1; load_val = 7'd5;
    #1;
    check("load_inc_done", 32'(done_inc), 0);
    tick();
    inc = 1'b0; load = 1'b0;
    check("load_inc_count", 32'(count_o), 5);

    // clr beats load and clears stickies
    check("pre_clr_unf", 32'(unf_sticky), 1);
    clr = 1'b1; load = 1'b1; load_val = 7'd7;
    tick();
    clr = 1'b0; load = 1'b0;
    check("clr_count", 32'(count_o), 0);
    check("clr_unf", 32'(unf_sticky), 0);
    check("clr_ovf", 32'(ovf_sticky), 0);

    // Window change: count outside window recovers to min
    max_count = 7'd59;
    load = 1'b1; load_val = 7'd50;
    tick();
    load = 1'b0;
    check("win_load", 32'(count_o), 50);
    min_count = 7'd3; max_count = 7'd30;
    inc = 1'b1;
    #1;
    check("win_done", 32'(done_inc), 0);
    tick();
    inc = 1'b0;
    check("win_count", 32'(count_o), 3);

    // Step 0 holds
    min_count = 7'd0; max_count = 7'd59;
    load = 1'b1; load_val = 7'd45;
    tick();
    load = 1'b0;
    step = 7'd0; inc = 1'b1;
    #1;
    check("step0_done", 32'(done_inc), 0);
    tick();
    inc = 1'b0; step = 7'd1;
    check("step0_count", 32'(count_o), 45);

    // Misconfigured window
    min_count = 7'd40; max_count = 7'd30;
    inc = 1'b1;
    #1;
    check("cfg_err", 32'(cfg_err), 1);
    check("cfg_done_inc", 32'(done_inc), 0);
    tick();
    check("cfg_inc_hold", 32'(count_o), 45);
    inc = 1'b0; dec = 1'b1;
    tick();
    dec = 1'b0;
    check("cfg_dec_hold", 32'(count_o), 45);
    load = 1'b1; load_val = 7'd35;
    tick();
    load = 1'b0;
    check("cfg_load_min", 32'(count_o), 40);

    // Cascade 59:59 -> 00:00
    min_count = 7'd0; max_count = 7'd59;
    load = 1'b1; load_val = 7'd59;
    m_load = 1'b1; m_load_val = 7'd59;
    tick();
    load = 1'b0; m_load = 1'b0;
    check("casc_sec_pre", 32'(count_o), 59);
    check("casc_min_pre", 32'(m_count), 59);
    inc = 1'b1; m_inc = 1'b1;
    #1;
    check("casc_sec_done", 32'(done_inc), 1);
    check("casc_min_done", 32'(m_done_inc), 1);
    tick();
    inc = 1'b0;
    check("casc_sec_count", 32'(count_o), 0);
    check("casc_min_count", 32'(m_count), 0);
    tick();
    check("casc_min_hold", 32'(m_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
